// File: rtl/poly_add_ctrl_pkg.sv
// ============================================================================
// Module  : poly_add_ctrl_pkg
// Purpose : Shared types, sizes and FSM encodings for the polynomial-add sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package poly_add_ctrl_pkg;

  localparam int BIT_WIDTH = 54;
  localparam int ADDR_W    = 12;
  localparam int MAX_LEN   = 4096;
  localparam int LEN_W     = 13;

  typedef logic [BIT_WIDTH-1:0] coeff_t;
  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [LEN_W-1:0]     len_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic len_t clamp_len(input len_t l);
    return (l > len_t'(MAX_LEN)) ? len_t'(MAX_LEN) : l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/poly_add_ctrl_if.sv
// ============================================================================
// Module  : poly_add_ctrl_if
// Purpose : Command, RAM read/write and status bundle of the poly-add sequencer.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface poly_add_ctrl_if;
  import poly_add_ctrl_pkg::*;

  logic   start;
  coeff_t q_in;
  len_t   len;
  addr_t  src_a_base;
  addr_t  src_b_base;
  addr_t  dst_base;
  logic   stall;
  logic   rd_en;
  addr_t  rd_addr_a;
  addr_t  rd_addr_b;
  coeff_t rd_data_a;
  coeff_t rd_data_b;
  logic   wr_en;
  addr_t  wr_addr;
  coeff_t wr_data;
  logic   busy;
  logic   done;

  modport master (
    output start, q_in, len, src_a_base, src_b_base, dst_base, stall,
           rd_data_a, rd_data_b,
    input  rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, q_in, len, src_a_base, src_b_base, dst_base, stall,
           rd_data_a, rd_data_b,
    output rd_en, rd_addr_a, rd_addr_b, wr_en, wr_addr, wr_data, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/poly_add_ctrl_mod_add.sv
// ============================================================================
// Module  : poly_add_ctrl_mod_add
// Purpose : Combinational (a+b) mod q for operands already reduced below q.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module poly_add_ctrl_mod_add
  import poly_add_ctrl_pkg::*;
(
  input  coeff_t i_a,
  input  coeff_t i_b,
  input  coeff_t i_q,
  output coeff_t o_sum
);

  logic   w_carry;
  coeff_t w_sum;

  // The carry out of the BIT_WIDTH-bit add means the true sum already exceeds q.
  assign {w_carry, w_sum} = {1'b0, i_a} + {1'b0, i_b};
  assign o_sum = (w_carry || (w_sum >= i_q)) ? (w_sum - i_q) : w_sum;

endmodule

`default_nettype wire

// File: rtl/poly_add_ctrl.sv
// ============================================================================
// Module  : poly_add_ctrl
// Purpose : Streams two coefficient vectors through mod_add, writing results back.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module poly_add_ctrl
  import poly_add_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  poly_add_ctrl_if.slave bus
);

  logic [1:0] r_state;
  addr_t      r_idx;
  len_t       r_len;
  coeff_t     r_q;
  addr_t      r_a_base;
  addr_t      r_b_base;
  addr_t      r_d_base;
  logic       r_v1;
  logic       r_v2;
  addr_t      r_waddr1;
  addr_t      r_waddr2;
  coeff_t     r_res;

  logic       w_issue;
  logic       w_last;
  len_t       w_len_c;
  coeff_t     w_sum;

  assign w_len_c = clamp_len(bus.len);
  assign w_issue = (r_state == ST_ISSUE) && !bus.stall;
  assign w_last  = ({1'b0, r_idx} == (r_len - len_t'(1)));

  poly_add_ctrl_mod_add u_mod_add (
    .i_a   (bus.rd_data_a),
    .i_b   (bus.rd_data_b),
    .i_q   (r_q),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_len    <= '0;
      r_q      <= '0;
      r_a_base <= '0;
      r_b_base <= '0;
      r_d_base <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_q      <= bus.q_in;
            r_len    <= w_len_c;
            r_a_base <= bus.src_a_base;
            r_b_base <= bus.src_b_base;
            r_d_base <= bus.dst_base;
            r_idx    <= '0;
            // An empty vector still passes through DRAIN so busy is seen for one cycle.
            r_state  <= (w_len_c == '0) ? ST_DRAIN : ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.stall) begin
            r_idx <= r_idx + addr_t'(1);
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // With S1 empty, any S2 entry is written this (unstalled) cycle.
          if (!bus.stall && !r_v1) r_state <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_waddr1 <= '0;
      r_waddr2 <= '0;
      r_res    <= '0;
    end else if (!bus.stall) begin
      r_v1     <= w_issue;
      r_waddr1 <= r_d_base + r_idx;
      r_v2     <= r_v1;
      r_waddr2 <= r_waddr1;
      r_res    <= w_sum;
    end
  end

  assign bus.rd_en     = w_issue;
  assign bus.rd_addr_a = r_a_base + r_idx;
  assign bus.rd_addr_b = r_b_base + r_idx;
  assign bus.wr_en     = r_v2 && !bus.stall;
  assign bus.wr_addr   = r_waddr2;
  assign bus.wr_data   = r_res;
  assign bus.busy      = (r_state == ST_ISSUE) || (r_state == ST_DRAIN);
  assign bus.done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_poly_add_ctrl.sv
// ============================================================================
// Module  : tb_poly_add_ctrl
// Purpose : Directed bench for poly_add_ctrl with RAM model and write scoreboard.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_poly_add_ctrl;

  localparam logic [53:0] c_Q = 54'h3F_FFFF_FFFE_D001;

  typedef struct {
    logic [11:0] addr;
    logic [53:0] data;
  } exp_t;

  logic clk;
  logic rstn;

  poly_add_ctrl_if iface ();

  poly_add_ctrl u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (iface)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [53:0] bank_a [4096];
  logic [53:0] bank_b [4096];
  exp_t        exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt, rd_cnt, busy_cnt, done_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [53:0] ref_add(input logic [53:0] a, input logic [53:0] b);
    logic [54:0] s;
    s = ({1'b0, a} + {1'b0, b}) % {1'b0, c_Q};
    return s[53:0];
  endfunction

  function automatic logic [53:0] rand_coeff();
    logic [63:0] r;
    r = {$urandom, $urandom};
    r = r % {10'd0, c_Q};
    return r[53:0];
  endfunction

  // 1-cycle-read RAM; writes land in bank A so in-place runs overwrite operand A.
  always @(posedge clk) begin
    if (iface.rd_en) begin
      iface.rd_data_a <= bank_a[iface.rd_addr_a];
      iface.rd_data_b <= bank_b[iface.rd_addr_b];
    end
    if (iface.wr_en) bank_a[iface.wr_addr] <= iface.wr_data;
  end

  always @(negedge clk) begin
    if (rstn) begin
      if (iface.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("wr_unexpected", 64'(iface.wr_addr), 64'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", 64'(iface.wr_addr), 64'(e.addr));
          check("wr_data", 64'(iface.wr_data), 64'(e.data));
        end
      end
      if (iface.rd_en) rd_cnt++;
      if (iface.busy)  busy_cnt++;
      if (iface.done)  done_cnt++;
      if (iface.stall) check("strobe_in_stall", 64'(iface.rd_en | iface.wr_en), 64'd0);
    end
  end

  task automatic push_exp(input int n, input int a_base, input int b_base, input int d_base);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      logic [11:0] aa, bb;
      aa     = 12'(a_base + i);
      bb     = 12'(b_base + i);
      e.addr = 12'(d_base + i);
      e.data = ref_add(bank_a[aa], bank_b[bb]);
      exp_q.push_back(e);
    end
  endtask

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; busy_cnt = 0; done_cnt = 0;
  endtask

  task automatic run_op(input int n_in, input int a_base, input int b_base, input int d_base,
                        input int stall_at, input bit poke);
    int n_eff, cnt, extra;
    n_eff = (n_in > 4096) ? 4096 : n_in;
    extra = (stall_at > 0) ? 3 : 0;
    @(negedge clk);
    #1;
    push_exp(n_eff, a_base, b_base, d_base);
    clear_counts();
    iface.q_in       = c_Q;
    iface.len        = 13'(n_in);
    iface.src_a_base = 12'(a_base);
    iface.src_b_base = 12'(b_base);
    iface.dst_base   = 12'(d_base);
    iface.start      = 1'b1;
    cnt = 0;
    while (1) begin
      @(negedge clk);
      cnt++;
      if (iface.done || cnt >= n_eff + 40) break;
      #1;
      iface.start = poke && (cnt == 2);
      if (poke && cnt == 2) begin
        iface.len      = 13'd9;
        iface.dst_base = 12'd300;
        iface.q_in     = 54'd17;
      end
      iface.stall = (stall_at > 0) && (cnt >= stall_at) && (cnt < stall_at + 3);
    end
    #1;
    iface.start = 1'b0;
    iface.stall = 1'b0;
    check("done_seen", 64'(iface.done), 64'd1);
    check("cycles", 64'(cnt), (n_eff == 0) ? 64'd2 : 64'(n_eff + 3 + extra));
    @(negedge clk);
    check("done_pulse", 64'(iface.done), 64'd0);
    check("wr_count", 64'(wr_cnt), 64'(n_eff));
    check("rd_count", 64'(rd_cnt), 64'(n_eff));
    check("busy_cycles", 64'(busy_cnt), (n_eff == 0) ? 64'd1 : 64'(n_eff + 2 + extra));
    check("done_count", 64'(done_cnt), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [53:0] exp1 [4];
    int cnt;
    exp1[0] = 54'd0;
    exp1[1] = c_Q - 54'd2;
    exp1[2] = 54'd0;
    exp1[3] = 54'd12;
    clear_counts();
    rstn             = 1'b0;
    iface.start      = 1'b0;
    iface.stall      = 1'b0;
    iface.q_in       = '0;
    iface.len        = '0;
    iface.src_a_base = '0;
    iface.src_b_base = '0;
    iface.dst_base   = '0;
    iface.rd_data_a  = '0;
    iface.rd_data_b  = '0;
    for (int i = 0; i < 4096; i++) begin
      bank_a[i] <= rand_coeff();
      bank_b[i] <= rand_coeff();
    end
    repeat (3) @(negedge clk);
    check("rst_rd_en",   64'(iface.rd_en),     64'd0);
    check("rst_wr_en",   64'(iface.wr_en),     64'd0);
    check("rst_busy",    64'(iface.busy),      64'd0);
    check("rst_done",    64'(iface.done),      64'd0);
    check("rst_rd_addr", 64'(iface.rd_addr_a), 64'd0);
    check("rst_wr_addr", 64'(iface.wr_addr),   64'd0);
    check("rst_wr_data", 64'(iface.wr_data),   64'd0);
    #1 rstn = 1'b1;

    // Edge-value vector, with a start pulse injected mid-run that must be ignored.
    bank_a[0] <= 54'd0;  bank_a[1] <= c_Q - 54'd1; bank_a[2] <= c_Q - 54'd1; bank_a[3] <= 54'd5;
    bank_b[100] <= 54'd0; bank_b[101] <= c_Q - 54'd1; bank_b[102] <= 54'd1; bank_b[103] <= 54'd7;
    run_op(4, 0, 100, 200, 0, 1'b1);
    for (int i = 0; i < 4; i++) check("dst_len4", 64'(bank_a[200 + i]), 64'(exp1[i]));

    run_op(0, 0, 0, 0, 0, 1'b0);
    run_op(4096, 0, 0, 0, 0, 1'b0);
    run_op(8191, 0, 0, 0, 0, 1'b0);
    run_op(16, 10, 20, 500, 6, 1'b0);
    run_op(4, 4094, 50, 4094, 0, 1'b0);

    // Reset while the eighth-indexed read is being issued.
    @(negedge clk);
    #1;
    clear_counts();
    push_exp(32, 0, 0, 2000);
    iface.len = 13'd32; iface.src_a_base = 12'd0; iface.src_b_base = 12'd0;
    iface.dst_base = 12'd2000; iface.start = 1'b1;
    @(negedge clk);
    #1 iface.start = 1'b0;
    cnt = 0;
    while (!(iface.rd_en && iface.rd_addr_a == 12'd8) && cnt < 40) begin
      @(negedge clk);
      #1;
      cnt++;
    end
    check("rst_wait_idx8", 64'(cnt < 40), 64'd1);
    rstn = 1'b0;
    #1;
    check("midrst_busy",  64'(iface.busy),  64'd0);
    check("midrst_rd_en", 64'(iface.rd_en), 64'd0);
    check("midrst_wr_en", 64'(iface.wr_en), 64'd0);
    exp_q.delete();
    clear_counts();
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (6) @(negedge clk);
    check("midrst_no_wr",   64'(wr_cnt),   64'd0);
    check("midrst_no_done", 64'(done_cnt), 64'd0);
    check("midrst_idle",    64'(iface.busy), 64'd0);
    run_op(2, 1000, 1000, 1100, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
